instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction sequencer for the simple processor. It fetches 9-bit instruction words from a synchronous program memory and presents each one to the control unit on IR, with the immediate word on DIN for mvi. It starts each instruction with a one-cycle Run pulse, waits for the control unit's Done, and then advances the program counter. It is the initiator side of the Run/Done handshake and sits between program memory and the control unit/datapath.

## Interface
- ADDR_W, 5: program-memory address width; the memory holds 2^ADDR_W words.
- clk  input  1  system clock; all state changes on the rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- Start  input  1  level; starts execution from address 0 when the block is idle or halted.
- MemAddr  output  ADDR_W  program-memory read address (equals the PC register).
- MemData  input  9  memory read data, valid one cycle after MemAddr.
- IR  output  9  instruction word to the control unit; registered.
- DIN  output  9  immediate data word; registered.
- Run  output  1  one-cycle pulse that starts the control unit.
- Done  input  1  control unit completion.
- Busy  output  1  high in every state except IDLE and HALT.
- Halted  output  1  high in HALT.
- Error  output  1  sticky flag: illegal opcode seen (or watchdog expiry, see Configuration).
- InstrCount  output  8  count of retired instructions; wraps 255→0.

## Operation
- Opcode is IR[8:6]:
  - 0 mv, 2 add, 3 sub: single word.
  - 1 mvi: two words; the immediate is at PC+1.
  - 7: halt.
  - 4–6: illegal.
- States and transitions:
  - IDLE: wait for Start=1. On Start: PC←0, InstrCount←0, Error←0, go to FETCH.
  - FETCH: memory samples MemAddr=PC. Go to DECODE.
  - DECODE: latch the word in MemData.
    - Opcode 7: go to HALT. IR is not updated.
    - Opcode 4–6: Error←1, PC←PC+1, go to FETCH. Not issued, not counted.
    - Opcode 1: IR←MemData, PC←PC+1, go to FETCH_IMM.
    - Otherwise: IR←MemData, go to ISSUE.
  - FETCH_IMM: memory samples the immediate address. Go to LATCH_IMM.
  - LATCH_IMM: DIN←MemData, go to ISSUE.
  - ISSUE: Run=1 for exactly this cycle. Go to WAIT_DONE.
  - WAIT_DONE: Run=0. On Done=1: PC←PC+1, InstrCount←InstrCount+1, go to FETCH.
  - HALT: Halted=1; PC holds the address of the halt word. Start=1 behaves as it does in IDLE.
- PC arithmetic is modulo 2^ADDR_W:
  - Incrementing the last address wraps to 0.
  - An mvi at the last address takes its immediate from address 0.
- IR and DIN hold their values until overwritten. DIN is written only by mvi.
- Boundary conditions:
  - Start while Busy is ignored.
  - Done outside WAIT_DONE is ignored, including Done in the ISSUE cycle.
  - Done held high across instructions retires at most one instruction per WAIT_DONE entry.
  - Resetn low mid-instruction forces all registers to their reset values immediately; Run drops asynchronously.

## Timing
- Reset values:
  - MemAddr=0, IR=0, DIN=0, Run=0.
  - Busy=0, Halted=0, Error=0, InstrCount=0.
  - State IDLE.
- Start sampled in cycle t puts the block in FETCH at cycle t+1.
- Single-word instruction: FETCH, DECODE, ISSUE, then WAIT_DONE for ≥1 cycle. Run asserts 2 cycles after entering FETCH.
- mvi adds 2 cycles: Run asserts 4 cycles after entering FETCH.
- If Done=1 in the first WAIT_DONE cycle, the next FETCH is the following cycle. Minimum throughput is 4 cycles per single-word instruction and 6 per mvi.
- IR and DIN are stable from the ISSUE cycle until the next DECODE or LATCH_IMM.

## Configuration
- WATCHDOG_EN defined:
  - A 4-bit counter clears on entry to WAIT_DONE and increments each cycle Done=0.
  - When the count reaches 15 with Done still 0: Error←1, go to HALT. PC is left at the stalled instruction; InstrCount is not incremented.
  - Done=1 on the same cycle as expiry wins: the instruction retires normally.
- WATCHDOG_EN undefined: WAIT_DONE waits indefinitely and no counter is synthesized.

## Test plan
- Reset, then Start with mem[0]=9'o012 (mv R1,R2) and mem[1]=9'o700; Done returned 1 cycle after Run → IR=9'o012 during Run, then Halted=1, InstrCount=1, MemAddr=1, Error=0.
- mem[0]=9'o130 (mvi R3) and mem[1]=9'h0A5, then halt at mem[2] → DIN=9'h0A5 and IR=9'o130 in the ISSUE cycle; Run 4 cycles after the first FETCH; final PC=2.
- mem[0]=9'o401 (illegal), mem[1]=9'o201 (add), mem[2]=halt → Error=1, exactly one Run pulse, with IR=9'o201, InstrCount=1.
- ADDR_W=2: mem[3]=mvi, mem[0]=9'h055; start execution at mem[3] by preloading it with jumps of mv/NOP content → immediate taken from address 0; PC wraps 3→0.
- Hold Done=1 constantly → one retire per instruction, with Run spacing of 4 cycles. Pulse Resetn low during WAIT_DONE → all outputs return to reset values the same cycle.
- WATCHDOG_EN defined, Done never asserted → Halted=1 and Error=1 after 15 WAIT_DONE cycles, InstrCount=0. Undefined → still Busy after 100 cycles.

Source files
------------

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Summary  : Fetches 9-bit instructions from synchronous program memory and
//            drives the control unit through a Run/Done handshake.
//            Optional WATCHDOG_EN adds a WAIT_DONE stall watchdog.
// Revision : 1.0
// ============================================================================
module instr_sequencer #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              Resetn,
    input  logic              Start,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [8:0]        MemData,
    output logic [8:0]        IR,
    output logic [8:0]        DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [7:0]        InstrCount
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_FETCH_IMM = 3'd3,
        S_LATCH_IMM = 3'd4,
        S_ISSUE     = 3'd5,
        S_WAIT_DONE = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [8:0]        ir_q, ir_d;
    logic [8:0]        din_q, din_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
`ifdef WATCHDOG_EN
    localparam logic [3:0] WD_LIMIT = 4'd15;
    logic [3:0]        wd_q, wd_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        din_d   = din_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef WATCHDOG_EN
        wd_d    = wd_q;
`endif
        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    pc_d    = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH:     state_d = S_DECODE;
            S_DECODE: begin
                case (MemData[8:6])
                    3'd7:             state_d = S_HALT;
                    3'd4, 3'd5, 3'd6: begin
                        // Illegal words are skipped: flagged but never issued.
                        err_d   = 1'b1;
                        pc_d    = pc_q + PC_ONE;
                        state_d = S_FETCH;
                    end
                    3'd1: begin
                        ir_d    = MemData;
                        pc_d    = pc_q + PC_ONE;
                        state_d = S_FETCH_IMM;
                    end
                    default: begin
                        ir_d    = MemData;
                        state_d = S_ISSUE;
                    end
                endcase
            end
            S_FETCH_IMM: state_d = S_LATCH_IMM;
            S_LATCH_IMM: begin
                din_d   = MemData;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
`ifdef WATCHDOG_EN
                wd_d    = 4'd0;
`endif
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (Done) begin
                    pc_d    = pc_q + PC_ONE;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = S_FETCH;
                end
`ifdef WATCHDOG_EN
                else if (wd_q == WD_LIMIT - 4'd1) begin
                    // Count is about to reach the limit: abandon the stalled instruction.
                    wd_d    = WD_LIMIT;
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wd_d    = wd_q + 4'd1;
                end
`endif
            end
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            din_q   <= din_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef WATCHDOG_EN
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            wd_q <= 4'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    // Run decodes straight from the state register so reset drops it at once.
    assign Run        = (state_q == S_ISSUE);
    assign Busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign Halted     = (state_q == S_HALT);
    assign MemAddr    = pc_q;
    assign IR         = ir_q;
    assign DIN        = din_q;
    assign Error      = err_q;
    assign InstrCount = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Summary  : Directed self-checking bench for instr_sequencer (ADDR_W=5 and 2).
// Revision : 1.0
// ============================================================================
module tb_instr_sequencer;

    logic clk = 1'b0;
    logic Resetn = 1'b0;

    logic       a_Start = 1'b0, a_Done = 1'b0;
    logic [4:0] a_MemAddr;
    logic [8:0] a_MemData, a_IR, a_DIN;
    logic       a_Run, a_Busy, a_Halted, a_Error;
    logic [7:0] a_InstrCount;

    logic       b_Start = 1'b0, b_Done = 1'b0;
    logic [1:0] b_MemAddr;
    logic [8:0] b_MemData, b_IR, b_DIN;
    logic       b_Run, b_Busy, b_Halted, b_Error;
    logic [7:0] b_InstrCount;

    logic [8:0] mem_a [32];
    logic [8:0] mem_b [4];

    int total = 0;
    int bad   = 0;

    logic [8:0] run_ir[$];
    logic [8:0] run_din[$];
    int         run_at[$];

    always #5 clk = ~clk;

    always @(posedge clk) a_MemData <= mem_a[a_MemAddr];
    always @(posedge clk) b_MemData <= mem_b[b_MemAddr];

    instr_sequencer #(.ADDR_W(5)) u_dut_a (
        .clk(clk), .Resetn(Resetn), .Start(a_Start), .MemAddr(a_MemAddr),
        .MemData(a_MemData), .IR(a_IR), .DIN(a_DIN), .Run(a_Run), .Done(a_Done),
        .Busy(a_Busy), .Halted(a_Halted), .Error(a_Error), .InstrCount(a_InstrCount)
    );

    instr_sequencer #(.ADDR_W(2)) u_dut_b (
        .clk(clk), .Resetn(Resetn), .Start(b_Start), .MemAddr(b_MemAddr),
        .MemData(b_MemData), .IR(b_IR), .DIN(b_DIN), .Run(b_Run), .Done(b_Done),
        .Busy(b_Busy), .Halted(b_Halted), .Error(b_Error), .InstrCount(b_InstrCount)
    );

    task automatic load_a(input logic [8:0] w0, input logic [8:0] w1,
                          input logic [8:0] w2, input logic [8:0] w3);
        for (int i = 0; i < 32; i++) mem_a[i] = 9'o700;
        mem_a[0] = w0; mem_a[1] = w1; mem_a[2] = w2; mem_a[3] = w3;
    endtask

    // Leaves the caller one step past the Start edge, i.e. in the FETCH cycle.
    task automatic start_a;
        @(posedge clk); #1;
        a_Start = 1'b1;
        @(posedge clk); #1;
        a_Start = 1'b0;
    endtask

    // mode 0: Done in the cycle after Run; 1: Done held high; 2: Done never.
    task automatic run_a(input int budget, input int mode, input logic hold_start,
                         output int cyc, output bit timeout);
        logic prev_run;
        prev_run = 1'b0;
        cyc = 0;
        timeout = 1'b1;
        run_ir.delete(); run_din.delete(); run_at.delete();
        while (cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (a_Run) begin
                run_ir.push_back(a_IR);
                run_din.push_back(a_DIN);
                run_at.push_back(cyc);
            end
            a_Done = (mode == 1) ? 1'b1 : (mode == 0) ? prev_run : 1'b0;
            prev_run = a_Run;
            if (a_Halted) begin
                timeout = 1'b0;
                a_Start = 1'b0;
                break;
            end
            a_Start = hold_start;
        end
        a_Done = 1'b0;
        a_Start = 1'b0;
    endtask

    task automatic test_reset;
        Resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_MemAddr !== 5'd0) begin bad++; $display("FAIL reset_memaddr got=%0d want=0", a_MemAddr); end
        total++; if (a_IR !== 9'd0 || a_DIN !== 9'd0) begin bad++; $display("FAIL reset_ir_din got=%h/%h want=0/0", a_IR, a_DIN); end
        total++; if ({a_Run, a_Busy, a_Halted, a_Error} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {a_Run, a_Busy, a_Halted, a_Error}); end
        total++; if (a_InstrCount !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", a_InstrCount); end
        Resetn = 1'b1;
        a_Done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_Done = 1'b0;
        total++; if (a_Busy !== 1'b0 || a_Run !== 1'b0) begin bad++; $display("FAIL idle_done_ignored busy=%b run=%b want=0/0", a_Busy, a_Run); end
    endtask

    task automatic test_single;
        int cyc; bit to;
        load_a(9'o012, 9'o700, 9'o700, 9'o700);
        start_a();
        total++; if (a_Busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", a_Busy); end
        run_a(40, 0, 1'b0, cyc, to);
        total++; if (to !== 1'b0 || cyc !== 6) begin bad++; $display("FAIL single_halt_cycle got=%0d timeout=%0d want=6", cyc, to); end
        total++; if (run_at.size() !== 1 || run_at[0] !== 2) begin bad++; $display("FAIL single_run got_n=%0d want_n=1 at=2", run_at.size()); end
        total++; if (run_ir.size() < 1 || run_ir[0] !== 9'o012) begin bad++; $display("FAIL single_ir_at_run got=%o want=012", (run_ir.size() > 0) ? run_ir[0] : 9'h1ff); end
        total++; if (a_InstrCount !== 8'd1 || a_MemAddr !== 5'd1) begin bad++; $display("FAIL single_final cnt=%0d pc=%0d want=1/1", a_InstrCount, a_MemAddr); end
        total++; if (a_Error !== 1'b0 || a_Busy !== 1'b0 || a_IR !== 9'o012) begin bad++; $display("FAIL single_state err=%b busy=%b ir=%o want=0/0/012", a_Error, a_Busy, a_IR); end
    endtask

    task automatic test_mvi;
        int cyc; bit to;
        load_a(9'o130, 9'h0A5, 9'o700, 9'o700);
        start_a();
        run_a(40, 0, 1'b0, cyc, to);
        total++; if (to !== 1'b0 || cyc !== 8) begin bad++; $display("FAIL mvi_halt_cycle got=%0d timeout=%0d want=8", cyc, to); end
        total++; if (run_at.size() !== 1 || run_at[0] !== 4) begin bad++; $display("FAIL mvi_run_latency got_n=%0d want_n=1 at=4", run_at.size()); end
        total++; if (run_ir.size() < 1 || run_ir[0] !== 9'o130 || run_din[0] !== 9'h0A5) begin bad++; $display("FAIL mvi_ir_din got=%o/%h want=130/0a5", (run_ir.size() > 0) ? run_ir[0] : 9'h1ff, (run_din.size() > 0) ? run_din[0] : 9'h1ff); end
        total++; if (a_MemAddr !== 5'd2 || a_InstrCount !== 8'd1) begin bad++; $display("FAIL mvi_final pc=%0d cnt=%0d want=2/1", a_MemAddr, a_InstrCount); end
    endtask

    task automatic test_illegal;
        int cyc; bit to;
        load_a(9'o401, 9'o201, 9'o700, 9'o700);
        start_a();
        run_a(40, 0, 1'b0, cyc, to);
        total++; if (to !== 1'b0 || cyc !== 8) begin bad++; $display("FAIL illegal_halt_cycle got=%0d timeout=%0d want=8", cyc, to); end
        total++; if (run_at.size() !== 1 || run_at[0] !== 4) begin bad++; $display("FAIL illegal_runs got_n=%0d want_n=1 at=4", run_at.size()); end
        total++; if (run_ir.size() < 1 || run_ir[0] !== 9'o201) begin bad++; $display("FAIL illegal_ir got=%o want=201", (run_ir.size() > 0) ? run_ir[0] : 9'h1ff); end
        total++; if (a_Error !== 1'b1 || a_InstrCount !== 8'd1 || a_MemAddr !== 5'd2) begin bad++; $display("FAIL illegal_final err=%b cnt=%0d pc=%0d want=1/1/2", a_Error, a_InstrCount, a_MemAddr); end
    endtask

    task automatic test_back_to_back;
        int cyc; bit to;
        load_a(9'o012, 9'o201, 9'o312, 9'o700);
        start_a();
        total++; if (a_Error !== 1'b0 || a_InstrCount !== 8'd0) begin bad++; $display("FAIL restart_clears err=%b cnt=%0d want=0/0", a_Error, a_InstrCount); end
        run_a(60, 1, 1'b1, cyc, to);
        total++; if (to !== 1'b0 || cyc !== 14) begin bad++; $display("FAIL b2b_halt_cycle got=%0d timeout=%0d want=14", cyc, to); end
        total++; if (run_at.size() !== 3) begin bad++; $display("FAIL b2b_run_count got=%0d want=3", run_at.size()); end
        else begin
            total++; if (run_at[0] !== 2 || run_at[1] !== 6 || run_at[2] !== 10) begin bad++; $display("FAIL b2b_spacing got=%0d,%0d,%0d want=2,6,10", run_at[0], run_at[1], run_at[2]); end
            total++; if (run_ir[1] !== 9'o201 || run_ir[2] !== 9'o312) begin bad++; $display("FAIL b2b_ir got=%o,%o want=201,312", run_ir[1], run_ir[2]); end
        end
        total++; if (a_InstrCount !== 8'd3 || a_MemAddr !== 5'd3) begin bad++; $display("FAIL b2b_final cnt=%0d pc=%0d want=3/3", a_InstrCount, a_MemAddr); end
    endtask

    task automatic test_reset_mid;
        load_a(9'o130, 9'h0A5, 9'o012, 9'o700);
        start_a();
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            a_Done = (c == 5);
        end
        total++; if (a_Run !== 1'b1 || a_IR !== 9'o012 || a_DIN !== 9'h0A5) begin bad++; $display("FAIL mid_pre run=%b ir=%o din=%h want=1/012/0a5", a_Run, a_IR, a_DIN); end
        total++; if (a_InstrCount !== 8'd1 || a_MemAddr !== 5'd2) begin bad++; $display("FAIL mid_pre_pc cnt=%0d pc=%0d want=1/2", a_InstrCount, a_MemAddr); end
        #2;
        Resetn = 1'b0;
        #1;
        total++; if (a_Run !== 1'b0 || a_Busy !== 1'b0 || a_Halted !== 1'b0 || a_Error !== 1'b0) begin bad++; $display("FAIL mid_async_flags run=%b busy=%b halt=%b err=%b want=0000", a_Run, a_Busy, a_Halted, a_Error); end
        total++; if (a_MemAddr !== 5'd0 || a_IR !== 9'd0 || a_DIN !== 9'd0 || a_InstrCount !== 8'd0) begin bad++; $display("FAIL mid_async_regs pc=%0d ir=%o din=%h cnt=%0d want=0", a_MemAddr, a_IR, a_DIN, a_InstrCount); end
        a_Done = 1'b0;
        @(posedge clk); #1;
        Resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_Busy !== 1'b0) begin bad++; $display("FAIL mid_stays_idle busy=%b want=0", a_Busy); end
    endtask

    task automatic test_watchdog;
        int cyc; bit to;
        load_a(9'o012, 9'o700, 9'o700, 9'o700);
        start_a();
`ifdef WATCHDOG_EN
        run_a(40, 2, 1'b0, cyc, to);
        total++; if (to !== 1'b0 || cyc !== 18) begin bad++; $display("FAIL wd_expiry_cycle got=%0d timeout=%0d want=18", cyc, to); end
        total++; if (a_Error !== 1'b1 || a_InstrCount !== 8'd0 || a_MemAddr !== 5'd0) begin bad++; $display("FAIL wd_final err=%b cnt=%0d pc=%0d want=1/0/0", a_Error, a_InstrCount, a_MemAddr); end
`else
        run_a(100, 2, 1'b0, cyc, to);
        total++; if (to !== 1'b1 || a_Busy !== 1'b1 || a_Halted !== 1'b0) begin bad++; $display("FAIL nowd_waits timeout=%0d busy=%b halt=%b want=1/1/0", to, a_Busy, a_Halted); end
        total++; if (run_at.size() !== 1 || a_InstrCount !== 8'd0) begin bad++; $display("FAIL nowd_runs got_n=%0d cnt=%0d want=1/0", run_at.size(), a_InstrCount); end
`endif
        Resetn = 1'b0;
        @(posedge clk); #1;
        Resetn = 1'b1;
    endtask

    task automatic test_wrap;
        logic prev; bit halted;
        int nrun, at1, at3, hc;
        logic [8:0] ir1, din1, ir3, din3;
        logic [1:0] addr12;
        prev = 1'b0; halted = 1'b0; nrun = 0; at1 = -1; at3 = -1; hc = -1;
        ir1 = '0; din1 = '0; ir3 = '0; din3 = '0; addr12 = 2'd3;
        mem_b[0] = 9'h055; mem_b[1] = 9'o700; mem_b[2] = 9'o000; mem_b[3] = 9'o130;
        @(posedge clk); #1;
        b_Start = 1'b1;
        @(posedge clk); #1;
        b_Start = 1'b0;
        for (int c = 1; c <= 30 && !halted; c++) begin
            @(posedge clk); #1;
            if (b_Run) begin
                nrun++;
                if (nrun == 1) begin ir1 = b_IR; din1 = b_DIN; at1 = c; end
                if (nrun == 3) begin ir3 = b_IR; din3 = b_DIN; at3 = c; end
            end
            if (c == 12) addr12 = b_MemAddr;
            b_Done = prev;
            prev = b_Run;
            if (b_Halted) begin halted = 1'b1; hc = c; end
        end
        b_Done = 1'b0;
        total++; if (!halted || hc !== 18 || nrun !== 3) begin bad++; $display("FAIL wrap_flow halt_cyc=%0d runs=%0d want=18/3", hc, nrun); end
        total++; if (ir1 !== 9'h055 || din1 !== 9'o700 || at1 !== 4) begin bad++; $display("FAIL wrap_first ir=%h din=%o at=%0d want=055/700/4", ir1, din1, at1); end
        total++; if (addr12 !== 2'd0) begin bad++; $display("FAIL wrap_imm_addr got=%0d want=0", addr12); end
        total++; if (ir3 !== 9'o130 || din3 !== 9'h055 || at3 !== 14) begin bad++; $display("FAIL wrap_imm ir=%o din=%h at=%0d want=130/055/14", ir3, din3, at3); end
        total++; if (b_MemAddr !== 2'd1 || b_InstrCount !== 8'd3) begin bad++; $display("FAIL wrap_final pc=%0d cnt=%0d want=1/3", b_MemAddr, b_InstrCount); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem_a[i] = 9'o700;
        for (int i = 0; i < 4; i++) mem_b[i] = 9'o700;
        test_reset();
        test_single();
        test_mvi();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
